alu_op_sequencer: RTL

- Next-generation EX-stage ALU control for the RV32 core.
- Decodes ALUOp/Funct7/Funct3 into a parametrised-width ALU operation code, including branch-compare variants.
- Adds an FSM that sequences multi-cycle RV32M multiply/divide operations on an external MDU.
- Drives MDU start/kill, a pipeline stall and a result-select mux control.

---
 rtl/alu_op_sequencer_pkg.sv | 61 ++++++
 rtl/alu_op_sequencer_if.sv | 30 +++
 rtl/alu_op_sequencer_decode.sv | 68 ++++++
 rtl/alu_op_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer shared types: ALU op codes, ALUOp/FSM enums,
// Funct7 constants and small helpers.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_BGE  = 4'b1101;
  localparam logic [3:0] OP_BLTU = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1110;
  localparam logic [3:0] OP_BGEU = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_RI  = 2'b10,
    ALUOP_JL  = 2'b11
  } aluop_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic [3:0] base_op(
    input logic [2:0] f3
  );
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// EX-stage <-> ALU sequencer bundle. master = EX stage,
// slave = alu_op_sequencer.
interface alu_op_sequencer_if #(
  parameter int OP_WIDTH = 4
);
  logic                valid_in;
  logic                flush;
  logic [1:0]          ALUOp;
  logic [6:0]          Funct7;
  logic [2:0]          Funct3;
  logic [OP_WIDTH-1:0] Operation;
  logic                mdu_start;
  logic [2:0]          mdu_op;
  logic                mdu_kill;
  logic                stall;
  logic                result_sel;
  logic                illegal;

  modport master (
    output valid_in, flush, ALUOp, Funct7, Funct3,
    input  Operation, mdu_start, mdu_op, mdu_kill,
    input  stall, result_sel, illegal
  );

  modport slave (
    input  valid_in, flush, ALUOp, Funct7, Funct3,
    output Operation, mdu_start, mdu_op, mdu_kill,
    output stall, result_sel, illegal
  );
endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational ALUOp/Funct7/Funct3 decode into ALU op, M-request
// and illegal flag. Division ops accepted only with ALU_SEQ_DIV_EN.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic       valid,
  input  logic [1:0] aluop,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] op,
  output logic       m_req,
  output logic       illegal
);

`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic is_m;
  logic bad;

  always_comb begin
    op   = OP_ADD;
    is_m = 1'b0;
    bad  = 1'b0;
    unique case (aluop_e'(aluop))
      ALUOP_MEM: op = OP_ADD;
      ALUOP_JL:  op = OP_LUI;
      ALUOP_BR: begin
        unique case (funct3)
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_BEQ;
        endcase
      end
      ALUOP_RI: begin
        unique case (1'b1)
          funct7 == F7_BASE: op = base_op(funct3);
          funct7 == F7_ALT: begin
            if (funct3 == 3'b000)
              op = OP_SUB;
            else if (funct3 == 3'b101)
              op = OP_SRA;
            else
              bad = 1'b1;
          end
          funct7 == F7_MUL: begin
            // the ALU result is unused for M ops
            if (DIV_EN || !funct3[2])
              is_m = 1'b1;
            else
              bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
    endcase
  end

  assign m_req   = valid & is_m;
  assign illegal = valid & bad;

endmodule

// File: rtl/alu_op_sequencer.sv
// EX-stage ALU control with RV32M multi-cycle sequencer.
// Define ALU_SEQ_DIV_EN to sequence DIV/DIVU/REM/REMU on the MDU.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OP_WIDTH = 4,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32
) (
  input  logic clk,
  input  logic reset,
  alu_op_sequencer_if.slave bus
);

`ifdef ALU_SEQ_DIV_EN
  localparam int MAX_LAT =
    (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
`else
  localparam int MAX_LAT = MUL_LAT;
`endif
  localparam int CNT_W = cnt_width(MAX_LAT);

  if (OP_WIDTH < 4 || MUL_LAT < 1 || DIV_LAT < 1)
  begin : g_param_chk
    $error("alu_op_sequencer: bad parameters");
  end

  logic [3:0]       op4;
  logic             m_req;
  logic             illegal;
  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, lat_m1;
  logic [2:0]       mop, mop_nxt;
  logic             start, kill, stall, rsel;

  alu_op_decode u_dec (
    .valid   (bus.valid_in),
    .aluop   (bus.ALUOp),
    .funct7  (bus.Funct7),
    .funct3  (bus.Funct3),
    .op      (op4),
    .m_req   (m_req),
    .illegal (illegal)
  );

`ifdef ALU_SEQ_DIV_EN
  assign lat_m1 = bus.Funct3[2] ?
    CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
`else
  assign lat_m1 = CNT_W'(MUL_LAT - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      mop   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mop   <= mop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mop_nxt   = mop;
    start     = 1'b0;
    kill      = 1'b0;
    stall     = 1'b0;
    rsel      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (m_req && !bus.flush) begin
          start     = 1'b1;
          stall     = 1'b1;
          state_nxt = S_BUSY;
          cnt_nxt   = lat_m1;
          mop_nxt   = bus.Funct3;
        end
      end
      S_BUSY: begin
        if (bus.flush) begin
          kill      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          stall = 1'b1;
          if (cnt == '0)
            state_nxt = S_DONE;
          else
            cnt_nxt = cnt - 1'b1;
        end
      end
      S_DONE: begin
        // same instruction still in EX: no new accept here
        rsel      = !bus.flush;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.Operation  = OP_WIDTH'(op4);
  assign bus.mdu_start  = start;
  assign bus.mdu_op     = mop;
  assign bus.mdu_kill   = kill;
  assign bus.stall      = stall;
  assign bus.result_sel = rsel;
  assign bus.illegal    = illegal;

endmodule
